// File: rtl/message_framer_if.sv
// Upstream payload handshake and line-side byte stream of the message framer.
interface message_framer_if;
    logic [7:0] din;
    logic       din_vld;
    logic       din_sop;
    logic       din_eop;
    logic       din_type;
    logic       din_rdy;
    logic [7:0] dout;
    logic       dout_sop;
    logic       dout_eop;
    logic       dout_vld;
    logic       err;

    // Payload source and line sink.
    modport master (
        output din, din_vld, din_sop, din_eop, din_type,
        input  din_rdy, dout, dout_sop, dout_eop, dout_vld, err
    );

    // The framer itself.
    modport slave (
        input  din, din_vld, din_sop, din_eop, din_type,
        output din_rdy, dout, dout_sop, dout_eop, dout_vld, err
    );
endinterface

// File: rtl/message_framer.sv
// Store-and-forward line framer: buffers one payload message, then emits
// preamble, SFD, type, optional length, payload and a 32-bit additive FCS
// as a gap-free byte stream, followed by an inter-frame gap.
module message_framer #(
    parameter int unsigned BUF_DEPTH = 256,
    parameter int unsigned CTRL_LEN  = 64,
    parameter int unsigned IFG       = 12
) (
    input  logic            clk,
    input  logic            rst,
    message_framer_if.slave bus
);

    localparam int unsigned AW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [15:0] BufLimit  = 16'(BUF_DEPTH);
    localparam logic [15:0] CtrlLimit = 16'(CTRL_LEN);
    localparam logic [15:0] IfgLimit  = 16'(IFG);

    typedef enum logic [3:0] {
        StCollect, StPre, StSfd, StType, StLenH, StLenL, StPayload, StFcs, StGap
    } state_e;

    state_e state_q, state_d;

    logic        open_q, open_d;    // a message has started (sop seen, no eop yet)
    logic        ctype_q, ctype_d;  // 1 = control frame
    logic        ovf_q, ovf_d;      // overflow already reported for this message
    logic [15:0] cnt_q, cnt_d;      // stored payload bytes
    logic [15:0] step_q, step_d;    // payload index / FCS byte number / gap cycle
    logic [31:0] fcs_q, fcs_d;
    logic        err_q, err_d;

    logic [7:0]    mem [BUF_DEPTH];
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] rd_addr;
    logic [7:0]    pf_q;            // prefetched buffer byte at payload index step_q

    logic [7:0] dout_q, dout_d;
    logic       sop_q, sop_d;
    logic       eop_q, eop_d;
    logic       vld_q, vld_d;
    logic       rdy_q, rdy_d;

    logic        accept;
    logic [15:0] tx_len;
    logic [15:0] limit;
    logic [7:0]  pay_byte;

    assign accept   = bus.din_vld && (state_q == StCollect);
    assign tx_len   = ctype_q ? CtrlLimit : cnt_q;
    assign limit    = ctype_q ? CtrlLimit : BufLimit;
    // Control frames pad positions beyond the received count with zeros.
    assign pay_byte = (step_q < cnt_q) ? pf_q : 8'h00;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StCollect;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, collection bookkeeping and FCS accumulation.
    always_comb begin
        state_d = state_q;
        open_d  = open_q;
        ctype_d = ctype_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        fcs_d   = fcs_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = cnt_q[AW-1:0];
        wr_data = bus.din;

        unique case (state_q)
            StCollect: begin
                if (accept) begin
                    if (bus.din_sop) begin
                        // A second sop discards the partial message.
                        err_d   = open_q;
                        open_d  = 1'b1;
                        ctype_d = bus.din_type;
                        ovf_d   = 1'b0;
                        cnt_d   = 16'd1;
                        wr_en   = 1'b1;
                        wr_addr = '0;
                    end else if (open_q) begin
                        if (cnt_q < limit) begin
                            wr_en = 1'b1;
                            cnt_d = cnt_q + 16'd1;
                        end else if (!ovf_q) begin
                            err_d = 1'b1;
                            ovf_d = 1'b1;
                        end
                    end
                    if (bus.din_eop && (bus.din_sop || open_q)) begin
                        open_d  = 1'b0;
                        state_d = StPre;
                        step_d  = '0;
                        fcs_d   = '0;
                    end
                end
            end
            StPre:  state_d = StSfd;
            StSfd:  state_d = StType;
            StType: state_d = ctype_q ? StPayload : StLenH;
            StLenH: state_d = StLenL;
            StLenL: state_d = StPayload;
            StPayload: begin
                if (step_q >= tx_len) begin
                    state_d = StFcs;
                    step_d  = 16'd1;
                end
            end
            StFcs: begin
                if (step_q == 16'd4) begin
                    state_d = (IFG == 0) ? StCollect : StGap;
                    step_d  = 16'd1;
                end else begin
                    step_d = step_q + 16'd1;
                end
            end
            StGap: begin
                if (step_q >= IfgLimit) begin
                    state_d = StCollect;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 16'd1;
                end
            end
            default: state_d = StCollect;
        endcase

        // Every cycle that puts a payload byte on the line advances the index.
        if (state_d == StPayload) begin
            step_d = step_q + 16'd1;
            fcs_d  = fcs_q + {24'h0, pay_byte};
        end

        rd_addr = (state_d == StPayload) ? step_d[AW-1:0] : '0;
    end

    // Line outputs for the state being entered, so they can be registered.
    always_comb begin
        dout_d = 8'h00;
        sop_d  = 1'b0;
        eop_d  = 1'b0;
        vld_d  = 1'b1;
        rdy_d  = (state_d == StCollect);
        unique case (state_d)
            StPre: begin
                dout_d = 8'h55;
                sop_d  = 1'b1;
            end
            StSfd:     dout_d = 8'hD5;
            StType:    dout_d = ctype_q ? 8'h00 : 8'hD5;
            StLenH:    dout_d = cnt_q[15:8];
            StLenL:    dout_d = cnt_q[7:0];
            StPayload: dout_d = pay_byte;
            StFcs: begin
                case (step_d[2:0])
                    3'd1:    dout_d = fcs_q[31:24];
                    3'd2:    dout_d = fcs_q[23:16];
                    3'd3:    dout_d = fcs_q[15:8];
                    default: dout_d = fcs_q[7:0];
                endcase
                eop_d = (step_d == 16'd4);
            end
            default: vld_d = 1'b0;
        endcase
    end

    // Control registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            open_q  <= 1'b0;
            ctype_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            step_q  <= '0;
            fcs_q   <= '0;
            err_q   <= 1'b0;
            dout_q  <= 8'h00;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            open_q  <= open_d;
            ctype_q <= ctype_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            fcs_q   <= fcs_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            vld_q   <= vld_d;
            rdy_q   <= rdy_d;
        end
    end

    // Payload buffer with one-ahead read so payload bytes stream without bubbles.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        pf_q <= mem[rd_addr];
    end

    assign bus.din_rdy  = rdy_q;
    assign bus.dout     = dout_q;
    assign bus.dout_sop = sop_q;
    assign bus.dout_eop = eop_q;
    assign bus.dout_vld = vld_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_message_framer.sv
// Directed bench: a default-size framer plus a 16-byte-buffer instance that
// shares the same upstream stimulus.
module tb_message_framer;
    localparam int unsigned IFG = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    message_framer_if bus_a ();
    message_framer_if bus_b ();

    message_framer #(.BUF_DEPTH(256), .CTRL_LEN(64), .IFG(IFG)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    message_framer #(.BUF_DEPTH(16), .CTRL_LEN(8), .IFG(IFG)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    assign bus_b.din      = bus_a.din;
    assign bus_b.din_vld  = bus_a.din_vld;
    assign bus_b.din_sop  = bus_a.din_sop;
    assign bus_b.din_eop  = bus_a.din_eop;
    assign bus_b.din_type = bus_a.din_type;

    int n_tests = 0;
    int n_fail  = 0;
    int err_a   = 0;
    int err_b   = 0;
    logic [7:0] tx_q [$];
    logic [7:0] exp_q [$];

    // Count err pulses of each instance.
    always @(posedge clk) begin
        if (bus_a.err === 1'b1) err_a++;
        if (bus_b.err === 1'b1) err_b++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus_a.din      = 8'h00;
        bus_a.din_vld  = 1'b0;
        bus_a.din_sop  = 1'b0;
        bus_a.din_eop  = 1'b0;
        bus_a.din_type = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic sop, input logic eop, input logic typ);
        bus_a.din      = d;
        bus_a.din_vld  = 1'b1;
        bus_a.din_sop  = sop;
        bus_a.din_eop  = eop;
        bus_a.din_type = typ;
    endtask

    task automatic wait_rdy();
        int w = 0;
        while (!(bus_a.din_rdy && bus_b.din_rdy) && w < 300) begin
            step();
            w++;
        end
        chk("wait_rdy", {31'b0, bus_a.din_rdy && bus_b.din_rdy}, 32'd1);
    endtask

    task automatic send_msg(input logic typ);
        wait_rdy();
        for (int i = 0; i < tx_q.size(); i++) begin
            beat(tx_q[i], i == 0, i == tx_q.size() - 1, typ);
            step();
        end
        idle();
    endtask

    // Checks exp_q against the line of instance A (sel=0) or B (sel=1).
    task automatic check_frame(input logic sel, input string tag);
        int w = 0;
        logic [7:0] d;
        logic s, e, v;
        v = sel ? bus_b.dout_vld : bus_a.dout_vld;
        while (!v && w < 20) begin
            step();
            w++;
            v = sel ? bus_b.dout_vld : bus_a.dout_vld;
        end
        chk({tag, "_start"}, {31'b0, v}, 32'd1);
        for (int i = 0; i < exp_q.size(); i++) begin
            d = sel ? bus_b.dout : bus_a.dout;
            s = sel ? bus_b.dout_sop : bus_a.dout_sop;
            e = sel ? bus_b.dout_eop : bus_a.dout_eop;
            v = sel ? bus_b.dout_vld : bus_a.dout_vld;
            chk($sformatf("%s_byte%0d", tag, i), {24'b0, d}, {24'b0, exp_q[i]});
            chk($sformatf("%s_vld%0d", tag, i), {31'b0, v}, 32'd1);
            chk($sformatf("%s_sop%0d", tag, i), {31'b0, s}, {31'b0, i == 0});
            chk($sformatf("%s_eop%0d", tag, i), {31'b0, e}, {31'b0, i == exp_q.size() - 1});
            step();
        end
        v = sel ? bus_b.dout_vld : bus_a.dout_vld;
        chk({tag, "_end_vld"}, {31'b0, v}, 32'd0);
    endtask

    initial begin
        int e0;
        int n;
        idle();

        // Reset values.
        rst = 1'b1;
        step();
        step();
        chk("rst_rdy", {31'b0, bus_a.din_rdy}, 32'd1);
        chk("rst_dout", {24'b0, bus_a.dout}, 32'h00);
        chk("rst_sop", {31'b0, bus_a.dout_sop}, 32'd0);
        chk("rst_eop", {31'b0, bus_a.dout_eop}, 32'd0);
        chk("rst_vld", {31'b0, bus_a.dout_vld}, 32'd0);
        chk("rst_err", {31'b0, bus_a.err}, 32'd0);
        rst = 1'b0;
        step();

        // Stray bytes before any sop are ignored.
        beat(8'h99, 1'b0, 1'b1, 1'b0);
        step();
        idle();
        step();
        chk("stray_vld", {31'b0, bus_a.dout_vld}, 32'd0);
        chk("stray_rdy", {31'b0, bus_a.din_rdy}, 32'd1);

        // Data frame 5xDD 5xEE.
        e0 = err_a;
        tx_q = {};
        for (int i = 0; i < 5; i++) tx_q.push_back(8'hDD);
        for (int i = 0; i < 5; i++) tx_q.push_back(8'hEE);
        send_msg(1'b0);
        chk("data_rdy_low", {31'b0, bus_a.din_rdy}, 32'd0);
        exp_q = {8'h55, 8'hD5, 8'hD5, 8'h00, 8'h0A};
        for (int i = 0; i < 5; i++) exp_q.push_back(8'hDD);
        for (int i = 0; i < 5; i++) exp_q.push_back(8'hEE);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h08); exp_q.push_back(8'hF7);
        check_frame(1'b0, "data");
        chk("data_err", err_a - e0, 32'd0);

        // Control frame 20x11 44x22.
        e0 = err_a;
        tx_q = {};
        for (int i = 0; i < 20; i++) tx_q.push_back(8'h11);
        for (int i = 0; i < 44; i++) tx_q.push_back(8'h22);
        send_msg(1'b1);
        exp_q = {8'h55, 8'hD5, 8'h00};
        for (int i = 0; i < 20; i++) exp_q.push_back(8'h11);
        for (int i = 0; i < 44; i++) exp_q.push_back(8'h22);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h07); exp_q.push_back(8'h2C);
        check_frame(1'b0, "ctrl");
        chk("ctrl_err", err_a - e0, 32'd0);

        // Short control frame 10x01, zero padded.
        e0 = err_a;
        tx_q = {};
        for (int i = 0; i < 10; i++) tx_q.push_back(8'h01);
        send_msg(1'b1);
        exp_q = {8'h55, 8'hD5, 8'h00};
        for (int i = 0; i < 10; i++) exp_q.push_back(8'h01);
        for (int i = 0; i < 54; i++) exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h0A);
        check_frame(1'b0, "short");
        chk("short_err", err_a - e0, 32'd0);

        // Overflow on the 16-byte instance: 20 bytes 01..14.
        e0 = err_b;
        tx_q = {};
        for (int i = 1; i <= 20; i++) tx_q.push_back(8'(i));
        send_msg(1'b0);
        exp_q = {8'h55, 8'hD5, 8'hD5, 8'h00, 8'h10};
        for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
        exp_q.push_back(8'h00); exp_q.push_back(8'h88);
        check_frame(1'b1, "ovf");
        chk("ovf_err", err_b - e0, 32'd1);

        // Back-to-back: a sop is held during transmission and the gap.
        tx_q = {8'h10, 8'h20, 8'h30};
        send_msg(1'b0);
        beat(8'h77, 1'b1, 1'b0, 1'b0);
        chk("b2b_rdy_low", {31'b0, bus_a.din_rdy}, 32'd0);
        exp_q = {8'h55, 8'hD5, 8'hD5, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30,
                 8'h00, 8'h00, 8'h00, 8'h60};
        check_frame(1'b0, "b2b1");
        n = 0;
        while (!bus_a.din_rdy && n < 100) begin
            n++;
            step();
        end
        chk("b2b_gap_len", n, IFG);
        e0 = err_a;
        step();
        beat(8'h78, 1'b0, 1'b0, 1'b0);
        step();
        beat(8'h79, 1'b0, 1'b0, 1'b0);
        step();
        beat(8'hA1, 1'b1, 1'b0, 1'b0);
        step();
        beat(8'hA2, 1'b0, 1'b1, 1'b0);
        step();
        idle();
        exp_q = {8'h55, 8'hD5, 8'hD5, 8'h00, 8'h02, 8'hA1, 8'hA2,
                 8'h00, 8'h00, 8'h01, 8'h43};
        check_frame(1'b0, "b2b2");
        chk("b2b_err", err_a - e0, 32'd1);

        // Reset mid-payload, then a 1-byte data frame.
        tx_q = {};
        for (int i = 0; i < 10; i++) tx_q.push_back(8'h5A);
        send_msg(1'b0);
        for (int i = 0; i < 7; i++) step();
        chk("midrst_was_vld", {31'b0, bus_a.dout_vld}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_vld", {31'b0, bus_a.dout_vld}, 32'd0);
        chk("midrst_rdy", {31'b0, bus_a.din_rdy}, 32'd1);
        chk("midrst_dout", {24'b0, bus_a.dout}, 32'h00);
        tx_q = {8'hAB};
        send_msg(1'b0);
        exp_q = {8'h55, 8'hD5, 8'hD5, 8'h00, 8'h01, 8'hAB, 8'h00, 8'h00, 8'h00, 8'hAB};
        check_frame(1'b0, "one");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
